// File: rtl/fetch_stage_if.sv
// Bundle of the fetch stage's instruction-memory, redirect and IF/ID slot signals.
// master = the fetch stage; slave = memory plus downstream pipeline.
interface fetch_stage_if #(
  parameter int XLEN = 32
);
  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_gnt;
  logic            imem_rvalid;
  logic [31:0]     imem_rdata;
  logic            imem_err;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            stall;
  logic            if_valid;
  logic [XLEN-1:0] if_pc;
  logic [31:0]     if_instr;
  logic            if_fault;
  logic            ifid_flush;

  modport master (
    output imem_req, imem_addr, if_valid, if_pc, if_instr, if_fault, ifid_flush,
    input  imem_gnt, imem_rvalid, imem_rdata, imem_err, redirect_valid, redirect_pc, stall
  );

  modport slave (
    input  imem_req, imem_addr, if_valid, if_pc, if_instr, if_fault, ifid_flush,
    output imem_gnt, imem_rvalid, imem_rdata, imem_err, redirect_valid, redirect_pc, stall
  );
endinterface

// File: rtl/fetch_stage.sv
// Instruction fetch: one outstanding memory request, one output slot backed by a
// one-entry hold buffer, and redirect handling that kills in-flight responses.
module fetch_stage #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_1000
) (
  input  logic         clk,
  input  logic         reset_n,
  fetch_stage_if.master bus
);

  typedef enum logic [1:0] {REQ, WAIT, HOLD, PARK} state_t;

  state_t          state_reg, state_next;
  logic [XLEN-1:0] pc_reg, pc_next;
  logic            kill_reg, kill_next;

  logic            slot_valid_reg;
  logic [XLEN-1:0] slot_pc_reg;
  logic [31:0]     slot_instr_reg;
  logic            slot_fault_reg;

  logic            hold_valid_reg;
  logic [31:0]     hold_instr_reg;
  logic            hold_fault_reg;

  logic            slot_free;
  logic            load_resp;
  logic            load_hold;
  logic            move_hold;

  always_comb begin
    state_next = state_reg;
    pc_next    = pc_reg;
    kill_next  = kill_reg;
    load_resp  = 1'b0;
    load_hold  = 1'b0;
    move_hold  = 1'b0;
    slot_free  = !slot_valid_reg || !bus.stall;

    if (bus.redirect_valid) begin
      pc_next = bus.redirect_pc & ~XLEN'(3);
      case (state_reg)
        REQ: begin
          // An accepted request still owes us a response, which must be discarded.
          state_next = bus.imem_gnt ? WAIT : REQ;
          kill_next  = bus.imem_gnt;
        end
        WAIT: begin
          state_next = bus.imem_rvalid ? REQ : WAIT;
          kill_next  = !bus.imem_rvalid;
        end
        default: begin
          state_next = REQ;
          kill_next  = 1'b0;
        end
      endcase
    end else begin
      case (state_reg)
        REQ: begin
          if (bus.imem_gnt) state_next = WAIT;
        end
        WAIT: begin
          if (bus.imem_rvalid) begin
            if (kill_reg) begin
              kill_next  = 1'b0;
              state_next = REQ;
            end else if (slot_free) begin
              load_resp  = 1'b1;
              state_next = bus.imem_err ? PARK : REQ;
              if (!bus.imem_err) pc_next = pc_reg + XLEN'(4);
            end else begin
              load_hold  = 1'b1;
              state_next = HOLD;
            end
          end
        end
        HOLD: begin
          if (!bus.stall && hold_valid_reg) begin
            move_hold  = 1'b1;
            state_next = hold_fault_reg ? PARK : REQ;
            if (!hold_fault_reg) pc_next = pc_reg + XLEN'(4);
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg <= REQ;
      pc_reg    <= RESET_PC;
      kill_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      pc_reg    <= pc_next;
      kill_reg  <= kill_next;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      slot_valid_reg <= 1'b0;
      slot_pc_reg    <= '0;
      slot_instr_reg <= '0;
      slot_fault_reg <= 1'b0;
      hold_valid_reg <= 1'b0;
      hold_instr_reg <= '0;
      hold_fault_reg <= 1'b0;
    end else begin
      if (bus.redirect_valid) begin
        slot_valid_reg <= 1'b0;
        hold_valid_reg <= 1'b0;
      end else begin
        if (load_resp) begin
          slot_valid_reg <= 1'b1;
          slot_pc_reg    <= pc_reg;
          slot_instr_reg <= bus.imem_rdata;
          slot_fault_reg <= bus.imem_err;
        end else if (move_hold) begin
          slot_valid_reg <= 1'b1;
          slot_pc_reg    <= pc_reg;
          slot_instr_reg <= hold_instr_reg;
          slot_fault_reg <= hold_fault_reg;
          hold_valid_reg <= 1'b0;
        end else if (slot_valid_reg && !bus.stall) begin
          slot_valid_reg <= 1'b0;
        end
        if (load_hold) begin
          hold_valid_reg <= 1'b1;
          hold_instr_reg <= bus.imem_rdata;
          hold_fault_reg <= bus.imem_err;
        end
      end
    end
  end

  assign bus.imem_req   = reset_n && (state_reg == REQ);
  assign bus.imem_addr  = pc_reg;
  assign bus.ifid_flush = bus.redirect_valid;
  assign bus.if_valid   = slot_valid_reg;
  assign bus.if_pc      = slot_pc_reg;
  assign bus.if_instr   = slot_instr_reg;
  assign bus.if_fault   = slot_fault_reg;

endmodule
